rd_avg_unit: RTL and testbench

- Datapath stage directly driven by the top-level controller.
- Consumes the READ and AVG command flags, captures one frame of 2^LOG2_N input samples into an internal sample buffer and accumulates their sum.
- Produces the frame average and raises the READ/AVG completion interrupts that the controller packs into fb_flags.
- Exposes a combinational buffer read port to the downstream COMP stage.

---
 rtl/rd_avg_unit_pkg.sv | 21 ++
 rtl/rd_avg_unit_sample_buf.sv | 32 +++
 rtl/rd_avg_unit.sv | 118 +++++++++++
 tb/tb_rd_avg_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_avg_unit_pkg.sv
// Shared definitions for rd_avg_unit: default widths, FSM encoding and the
// interrupt bit positions used when the controller packs fb_flags.
package rd_avg_unit_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int LOG2_N_DEF = 3;

   // Positions must match the controller's fb_flags layout
   localparam int INT_READ_BIT = 0;
   localparam int INT_AVG_BIT  = 1;
   localparam int INT_W        = 2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CAPT = 3'd1,
      ST_FULL = 3'd2,
      ST_CALC = 3'd3,
      ST_DONE = 3'd4
   } avg_state_t;

endpackage

// File: rtl/rd_avg_unit_sample_buf.sv
// N x DATA_W sample register file: synchronous write, asynchronous read,
// cleared only by the asynchronous reset.
module rd_avg_unit_sample_buf #(
   parameter int DATA_W = 8,
   parameter int LOG2_N = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [LOG2_N-1:0] wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [LOG2_N-1:0] rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   localparam int N = 1 << LOG2_N;

   logic [DATA_W-1:0] mem [N];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/rd_avg_unit.sv
// READ/AVG datapath stage: captures one frame of 2^LOG2_N samples, averages it
// and pulses completion interrupts. Define AVG_ROUND_EN for round-half-up averaging.
module rd_avg_unit
   import rd_avg_unit_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LOG2_N = LOG2_N_DEF,
   parameter int SUM_W  = DATA_W + LOG2_N
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_read,
   input  logic              cmd_avg,
   input  logic              dp_cnt_rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [LOG2_N-1:0] rd_idx,
   output logic [DATA_W-1:0] rd_sample,
   output logic [DATA_W-1:0] avg_out,
   output logic              int_read,
   output logic              int_avg
);

   localparam int              N    = 1 << LOG2_N;
   localparam logic [LOG2_N-1:0] LAST = LOG2_N'(N - 1);

   avg_state_t        state;
   logic [LOG2_N-1:0] cnt;
   logic [SUM_W-1:0]  acc;
   logic [DATA_W-1:0] avg_q;
   logic [INT_W-1:0]  int_flags;
   logic              capture;
   logic [DATA_W-1:0] avg_next;

   // A restart on the same edge wins over a capture, so the buffer write is gated too
   assign capture = (state == ST_CAPT) && cmd_read && in_valid && !dp_cnt_rst;

`ifdef AVG_ROUND_EN
   logic [SUM_W:0] acc_round;

   assign acc_round = {1'b0, acc} + (SUM_W + 1)'(N / 2);
   assign avg_next  = DATA_W'(acc_round >> LOG2_N);
`else
   assign avg_next  = DATA_W'(acc >> LOG2_N);
`endif

   rd_avg_unit_sample_buf #(
      .DATA_W (DATA_W),
      .LOG2_N (LOG2_N)
   ) u_sample_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (capture),
      .wr_idx  (cnt),
      .wr_data (in_data),
      .rd_idx  (rd_idx),
      .rd_data (rd_sample)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         acc       <= '0;
         avg_q     <= '0;
         int_flags <= '0;
      end else begin
         int_flags <= '0;
         if (dp_cnt_rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (cmd_read) begin
                     state <= ST_CAPT;
                     cnt   <= '0;
                     acc   <= '0;
                  end
               end
               ST_CAPT: begin
                  if (cmd_read && in_valid) begin
                     acc <= acc + SUM_W'(in_data);
                     cnt <= cnt + 1'b1;
                     if (cnt == LAST) begin
                        state                   <= ST_FULL;
                        int_flags[INT_READ_BIT] <= 1'b1;
                     end
                  end
               end
               // Buffer is frozen here; a lingering cmd_read is simply ignored
               ST_FULL: begin
                  if (cmd_avg) begin
                     state <= ST_CALC;
                  end
               end
               ST_CALC: begin
                  avg_q                  <= avg_next;
                  int_flags[INT_AVG_BIT] <= 1'b1;
                  state                  <= ST_DONE;
               end
               ST_DONE: begin
                  state <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign avg_out  = avg_q;
   assign int_read = int_flags[INT_READ_BIT];
   assign int_avg  = int_flags[INT_AVG_BIT];

endmodule

// File: tb/tb_rd_avg_unit.sv
// Self-checking bench for rd_avg_unit: directed frame scenarios plus a
// randomized run compared every cycle against a frame-level reference model.
module tb_rd_avg_unit;

   localparam int DATA_W = 8;
   localparam int LOG2_N = 3;
   localparam int N      = 8;

   logic              clk        = 1'b0;
   logic              reset      = 1'b1;
   logic              cmd_read   = 1'b0;
   logic              cmd_avg    = 1'b0;
   logic              dp_cnt_rst = 1'b0;
   logic              in_valid   = 1'b0;
   logic [DATA_W-1:0] in_data    = '0;
   logic [LOG2_N-1:0] rd_idx     = '0;
   logic [DATA_W-1:0] rd_sample;
   logic [DATA_W-1:0] avg_out;
   logic              int_read;
   logic              int_avg;

   int checks = 0;
   int passed = 0;

   always #10 clk = ~clk;

   rd_avg_unit #(
      .DATA_W (DATA_W),
      .LOG2_N (LOG2_N)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_read   (cmd_read),
      .cmd_avg    (cmd_avg),
      .dp_cnt_rst (dp_cnt_rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .rd_idx     (rd_idx),
      .rd_sample  (rd_sample),
      .avg_out    (avg_out),
      .int_read   (int_read),
      .int_avg    (int_avg)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      else
         passed++;
   endtask

   task automatic applyStimulus(input bit rd, input bit av, input bit rst,
                                input bit vld, input logic [DATA_W-1:0] d);
      @(negedge clk);
      cmd_read   = rd;
      cmd_avg    = av;
      dp_cnt_rst = rst;
      in_valid   = vld;
      in_data    = d;
   endtask

   // Reference model: the frame is a list of accepted samples; outputs follow from it
   int exp_buf [N];
   int exp_avg;
   bit exp_int_read;
   bit exp_int_avg;
   int frame_q [$];
   bit capturing;
   bit frame_full;
   int avg_stage;

   function automatic int frameAverage();
      int s = 0;
      foreach (frame_q[i]) s += frame_q[i];
`ifdef AVG_ROUND_EN
      return (s + N / 2) / N;
`else
      return s / N;
`endif
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         foreach (exp_buf[i]) exp_buf[i] = 0;
         exp_avg      = 0;
         exp_int_read = 0;
         exp_int_avg  = 0;
         frame_q.delete();
         capturing    = 0;
         frame_full   = 0;
         avg_stage    = 0;
      end else begin
         exp_int_read = 0;
         exp_int_avg  = 0;
         if (dp_cnt_rst) begin
            frame_q.delete();
            capturing  = 0;
            frame_full = 0;
            avg_stage  = 0;
         end else if (avg_stage == 1) begin
            exp_avg     = frameAverage();
            exp_int_avg = 1;
            avg_stage   = 2;
         end else if (avg_stage == 2) begin
            avg_stage = 0;
         end else if (frame_full) begin
            if (cmd_avg) begin
               frame_full = 0;
               avg_stage  = 1;
            end
         end else if (capturing) begin
            if (cmd_read && in_valid) begin
               exp_buf[frame_q.size()] = int'(in_data);
               frame_q.push_back(int'(in_data));
               if (frame_q.size() == N) begin
                  capturing    = 0;
                  frame_full   = 1;
                  exp_int_read = 1;
               end
            end
         end else if (cmd_read) begin
            frame_q.delete();
            capturing = 1;
         end
      end
   end

   always begin
      @(posedge clk);
      #2;
      checkOutput("int_read", int_read, exp_int_read);
      checkOutput("int_avg", int_avg, exp_int_avg);
      checkOutput("avg_out", avg_out, exp_avg);
      checkOutput("rd_sample", rd_sample, exp_buf[rd_idx]);
   end

   task automatic runAverage();
      applyStimulus(0, 1, 0, 0, '0);
      applyStimulus(0, 0, 0, 0, '0);
      checkOutput("avg_latency_early", int_avg, 1'b0);
      applyStimulus(0, 0, 0, 0, '0);
      checkOutput("avg_latency_pulse", int_avg, 1'b1);
   endtask

   initial begin
      logic [DATA_W-1:0] samp [N];
      int                sum;
      int                k;

      $display("[TB] starting rd_avg_unit bench");
      repeat (2) @(negedge clk);
      checkOutput("reset_avg_out", avg_out, 8'h00);
      checkOutput("reset_int_read", int_read, 1'b0);
      checkOutput("reset_int_avg", int_avg, 1'b0);
      checkOutput("reset_rd_sample", rd_sample, 8'h00);
      reset = 1'b0;

      // Frame of 1..8, then truncating / rounding average
      applyStimulus(1, 0, 0, 0, '0);
      for (int i = 1; i <= N; i++) applyStimulus(1, 0, 0, 1, DATA_W'(i));
      applyStimulus(1, 0, 0, 0, '0);
      checkOutput("frame_int_read", int_read, 1'b1);
      applyStimulus(0, 0, 0, 0, '0);
      checkOutput("frame_int_read_end", int_read, 1'b0);
      for (int i = 0; i < N; i++) begin
         rd_idx = LOG2_N'(i);
         #1;
         checkOutput("frame_buf", rd_sample, 32'(i + 1));
      end
      runAverage();
`ifdef AVG_ROUND_EN
      checkOutput("avg_1to8", avg_out, 8'd5);
`else
      checkOutput("avg_1to8", avg_out, 8'd4);
`endif
      applyStimulus(0, 0, 0, 0, '0);
      checkOutput("avg_pulse_end", int_avg, 1'b0);

      // Gapped input followed by overrun samples
      applyStimulus(1, 0, 0, 0, '0);
      k   = 0;
      sum = 0;
      while (k < N) begin
         applyStimulus(1, 0, 0, 0, DATA_W'($urandom));
         samp[k] = DATA_W'($urandom);
         sum += int'(samp[k]);
         applyStimulus(1, 0, 0, 1, samp[k]);
         k++;
      end
      repeat (3) applyStimulus(1, 0, 0, 1, 8'hFF);
      applyStimulus(0, 0, 0, 0, '0);
      for (int i = 0; i < N; i++) begin
         rd_idx = LOG2_N'(i);
         #1;
         checkOutput("gapped_buf", rd_sample, 32'(samp[i]));
      end
      runAverage();
`ifdef AVG_ROUND_EN
      checkOutput("gapped_avg", avg_out, 32'((sum + 4) / 8));
`else
      checkOutput("gapped_avg", avg_out, 32'(sum / 8));
`endif

      // Frame restart after a partial frame
      applyStimulus(1, 0, 0, 0, '0);
      repeat (5) applyStimulus(1, 0, 0, 1, DATA_W'($urandom));
      applyStimulus(1, 0, 1, 1, 8'h33);
      applyStimulus(1, 0, 0, 0, '0);
      repeat (N - 1) applyStimulus(1, 0, 0, 1, 8'hFF);
      applyStimulus(1, 0, 0, 1, 8'hFF);
      checkOutput("restart_no_early_int", int_read, 1'b0);
      applyStimulus(0, 0, 0, 0, '0);
      checkOutput("restart_int_read", int_read, 1'b1);
      runAverage();
      checkOutput("restart_avg", avg_out, 8'hFF);

      // Spurious cmd_avg in IDLE
      repeat (3) applyStimulus(0, 1, 0, 0, '0);
      applyStimulus(0, 0, 0, 0, '0);
      checkOutput("spurious_int_avg", int_avg, 1'b0);
      checkOutput("spurious_avg_hold", avg_out, 8'hFF);

      // Asynchronous reset in the middle of a frame
      applyStimulus(1, 0, 0, 0, '0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 8'h40);
      @(negedge clk);
      #3 reset = 1'b1;
      rd_idx = '0;
      #1;
      checkOutput("areset_avg_out", avg_out, 8'h00);
      checkOutput("areset_rd_sample", rd_sample, 8'h00);
      checkOutput("areset_int_read", int_read, 1'b0);
      @(negedge clk);
      reset    = 1'b0;
      cmd_read = 1'b1;
      in_valid = 1'b0;
      repeat (N - 1) applyStimulus(1, 0, 0, 1, 8'h10);
      applyStimulus(1, 0, 0, 1, 8'h10);
      checkOutput("areset_no_early_int", int_read, 1'b0);
      applyStimulus(0, 0, 0, 0, '0);
      checkOutput("areset_int_read", int_read, 1'b1);
      applyStimulus(0, 0, 1, 0, '0);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         applyStimulus(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 50) == 0,
                       ($urandom % 2) == 1, DATA_W'($urandom));
         rd_idx = LOG2_N'($urandom);
      end
      applyStimulus(0, 0, 0, 0, '0);
      @(negedge clk);

      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
